// File: rtl/ustream_gen2_pkg.sv
// Shared types and helpers for the dual-channel unary stream generator.
// State encoding plus a width-generic bit-reversal used by channel A.
`ifndef USTREAM_GEN2_PKG_SV
`define USTREAM_GEN2_PKG_SV

package ustream_gen2_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Reverse the low w bits of v (w <= 32); upper result bits are zero.
   function automatic logic [31:0] bitrev(
      input logic [31:0] v,
      input int unsigned w
   );
      logic [31:0] r;
      r = {<<{v}};
      return r >> (32 - w);
   endfunction

endpackage

`endif

// File: rtl/ustream_gen2_if.sv
// Start/operand request and stream/status outputs of the generator.
// master drives operands and start, slave produces the streams.
interface ustream_gen2_if #(
   parameter int BITWIDTH = 8
);
   logic                iStart;
   logic [BITWIDTH-1:0] iDataA;
   logic [BITWIDTH-1:0] iDataB;
   logic                oA;
   logic                oB;
   logic                oValid;
   logic                oBusy;
   logic                oDone;

   modport master (
      output iStart, iDataA, iDataB,
      input  oA, oB, oValid, oBusy, oDone
   );

   modport slave (
      input  iStart, iDataA, iDataB,
      output oA, oB, oValid, oBusy, oDone
   );
endinterface

// File: rtl/ustream_gen2_ucmp_sng.sv
// Stochastic number generator slice: one stream bit from a sequence value
// compared against the operand, optionally inverted.
module ucmp_sng #(
   parameter int BITWIDTH = 8,
   parameter bit INV      = 1'b0
) (
   input  logic [BITWIDTH-1:0] seq_i,
   input  logic [BITWIDTH-1:0] data_i,
   output logic                bit_o
);

   assign bit_o = (seq_i < data_i) ^ INV;

endmodule

// File: rtl/ustream_gen2.sv
// Dual-channel unary bitstream generator: van der Corput sequence on A,
// ramp on B, each stream exactly 2^BITWIDTH bits long.
module ustream_gen2
   import ustream_gen2_pkg::*;
#(
   parameter int BITWIDTH = 8,
   parameter bit INVB     = 1'b0
) (
   input  logic           iClk,
   input  logic           iRst,
   ustream_gen2_if.slave  bus
);

   state_e              state_q, state_d;
   logic [BITWIDTH-1:0] cnt_q, cnt_d;
   logic [BITWIDTH-1:0] a_q, a_d;
   logic [BITWIDTH-1:0] b_q, b_d;
   logic                oa_q, oa_d;
   logic                ob_q, ob_d;
   logic                valid_q, valid_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [BITWIDTH-1:0] seq_a;
   logic                cmp_a, cmp_b;
   logic                last;

   assign seq_a = BITWIDTH'(bitrev(32'(cnt_q), BITWIDTH));
   assign last  = (cnt_q == '1);

   ucmp_sng #(
      .BITWIDTH (BITWIDTH),
      .INV      (1'b0)
   ) u_sng_a (
      .seq_i  (seq_a),
      .data_i (a_q),
      .bit_o  (cmp_a)
   );

   ucmp_sng #(
      .BITWIDTH (BITWIDTH),
      .INV      (INVB)
   ) u_sng_b (
      .seq_i  (cnt_q),
      .data_i (b_q),
      .bit_o  (cmp_b)
   );

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (bus.iStart) state_d = RUN;
         RUN:  if (last)       state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      oa_d    = 1'b0;
      ob_d    = 1'b0;
      valid_d = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            // valid_q high here means the previous edge emitted the last bit
            done_d = valid_q;
            if (bus.iStart) begin
               a_d    = bus.iDataA;
               b_d    = bus.iDataB;
               cnt_d  = '0;
               busy_d = 1'b1;
            end
         end
         RUN: begin
            oa_d    = cmp_a;
            ob_d    = cmp_b;
            valid_d = 1'b1;
            cnt_d   = cnt_q + BITWIDTH'(1);
            if (last) busy_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         oa_q    <= 1'b0;
         ob_q    <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         oa_q    <= oa_d;
         ob_q    <= ob_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.oA     = oa_q;
   assign bus.oB     = ob_q;
   assign bus.oValid = valid_q;
   assign bus.oBusy  = busy_q;
   assign bus.oDone  = done_q;

endmodule

// File: tb/tb_ustream_gen2.sv
// Bench for ustream_gen2: INVB=0 and INVB=1 instances against a
// stream-level model, plus literal count/pattern checks per run.
module tb_ustream_gen2;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] da, db;

   int total = 0;
   int bad   = 0;

   ustream_gen2_if #(.BITWIDTH(8)) bus0 ();
   ustream_gen2_if #(.BITWIDTH(8)) bus1 ();

   assign bus0.iStart = start;
   assign bus0.iDataA = da;
   assign bus0.iDataB = db;
   assign bus1.iStart = start;
   assign bus1.iDataA = 8'd192;
   assign bus1.iDataB = 8'd64;

   ustream_gen2 #(.BITWIDTH(8), .INVB(1'b0)) dut0 (
      .iClk (clk),
      .iRst (rst),
      .bus  (bus0)
   );

   ustream_gen2 #(.BITWIDTH(8), .INVB(1'b1)) dut1 (
      .iClk (clk),
      .iRst (rst),
      .bus  (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] k);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = k[7-i];
      return r;
   endfunction

   // Stream-level model: bit k of a run is defined directly from operands.
   int         m_pos;
   bit         m_run;
   logic [7:0] ma, mb, ma1, mb1;
   logic       e_a, e_b, e_a1, e_b1, e_v, e_busy, e_done;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_run = 0; m_pos = 0;
         ma = 0; mb = 0; ma1 = 0; mb1 = 0;
         e_a = 0; e_b = 0; e_a1 = 0; e_b1 = 0;
         e_v = 0; e_busy = 0; e_done = 0;
      end else begin
         if (m_run) begin
            e_a  = rev8(m_pos[7:0]) < ma;
            e_b  = m_pos < int'(mb);
            e_a1 = rev8(m_pos[7:0]) < ma1;
            e_b1 = !(m_pos < int'(mb1));
            e_v  = 1;
            e_done = 0;
            m_pos++;
            if (m_pos == 256) m_run = 0;
         end else begin
            e_done = e_v;
            e_v = 0;
            e_a = 0; e_b = 0; e_a1 = 0; e_b1 = 0;
            if (start) begin
               ma = da; mb = db;
               ma1 = 8'd192; mb1 = 8'd64;
               m_pos = 0;
               m_run = 1;
            end
         end
         e_busy = m_run;
      end
   end

   // Per-run statistics and downstream scaled subtractor/adder (TFF type)
   int   nA, nB, nA1, nB1, nS, vcnt, dcnt, obs;
   logic abits [0:511];
   logic bbits [0:511];
   logic tff;

   task automatic clr();
      nA = 0; nB = 0; nA1 = 0; nB1 = 0; nS = 0;
      vcnt = 0; dcnt = 0; obs = 0; tff = 0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("valid", bus0.oValid, e_v);
         chk("a", bus0.oA, e_a);
         chk("b", bus0.oB, e_b);
         chk("busy", bus0.oBusy, e_busy);
         chk("done", bus0.oDone, e_done);
         chk("valid1", bus1.oValid, e_v);
         chk("a1", bus1.oA, e_a1);
         chk("b1", bus1.oB, e_b1);
         chk("done1", bus1.oDone, e_done);
         if (bus0.oValid) begin
            if (obs < 512) begin
               abits[obs] = bus0.oA;
               bbits[obs] = bus0.oB;
            end
            obs++;
            vcnt++;
            nA += int'(bus0.oA);
            nB += int'(bus0.oB);
         end
         if (bus0.oDone) dcnt++;
         if (bus1.oValid) begin
            nA1 += int'(bus1.oA);
            nB1 += int'(bus1.oB);
            nS  += int'((bus1.oA & bus1.oB) |
                        ((bus1.oA ^ bus1.oB) & tff));
            if (bus1.oA ^ bus1.oB) tff = ~tff;
         end
      end
   end

   task automatic wait_done(string nm);
      int n;
      n = 0;
      do begin
         @(negedge clk); #1;
         n++;
      end while (!bus0.oDone && n < 400);
      chk(nm, bus0.oDone, 1);
   endtask

   task automatic run(logic [7:0] a, logic [7:0] b, string nm);
      @(negedge clk); #1;
      da = a; db = b; start = 1; clr();
      @(negedge clk); #1;
      start = 0;
      wait_done(nm);
   endtask

   task automatic chk_rst_outs(string nm);
      chk({nm, "_v"}, bus0.oValid, 0);
      chk({nm, "_a"}, bus0.oA, 0);
      chk({nm, "_b"}, bus0.oB, 0);
      chk({nm, "_busy"}, bus0.oBusy, 0);
      chk({nm, "_done"}, bus0.oDone, 0);
      chk({nm, "_b1"}, bus1.oB, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; start = 0; da = 0; db = 0;
      clr();
      repeat (3) @(negedge clk);
      #1 chk_rst_outs("rst0");
      rst = 0;

      // half-scale A alternates; B=3 gives three leading ones
      run(8'd128, 8'd3, "t1_done");
      chk("t1_nA", nA, 128);
      chk("t1_nB", nB, 3);
      chk("t1_vcnt", vcnt, 256);
      chk("t1_dcnt", dcnt, 1);
      chk("t1_a0", abits[0], 1);
      chk("t1_a1", abits[1], 0);
      chk("t1_a2", abits[2], 1);
      chk("t1_a3", abits[3], 0);
      chk("t1_b2", bbits[2], 1);
      chk("t1_b3", bbits[3], 0);
      chk("inv_nA1", nA1, 192);
      chk("inv_nB1", nB1, 192);
      chk("inv_sub", (nS >= 191 && nS <= 193), 1);

      run(8'd0, 8'd255, "t2_done");
      chk("t2_nA", nA, 0);
      chk("t2_nB", nB, 255);
      chk("t2_b254", bbits[254], 1);
      chk("t2_b255", bbits[255], 0);

      run(8'd255, 8'd0, "t3_done");
      chk("t3_nA", nA, 255);
      chk("t3_nB", nB, 0);
      chk("t3_a254", abits[254], 1);
      chk("t3_a255", abits[255], 0);
      chk("t3_vcnt", vcnt, 256);
      @(negedge clk); #1;
      chk("t3_idle_v", bus0.oValid, 0);
      chk("t3_idle_busy", bus0.oBusy, 0);

      // abort mid-stream, then a fresh run must be clean
      @(negedge clk); #1;
      da = 8'd200; db = 8'd100; start = 1;
      @(negedge clk); #1;
      start = 0;
      repeat (100) @(negedge clk);
      #1 chk("t4_midrun", bus0.oBusy, 1);
      rst = 1;
      #1 chk_rst_outs("t4_rst");
      repeat (2) @(negedge clk);
      #1 chk_rst_outs("t4_rst2");
      rst = 0;
      run(8'd64, 8'd7, "t4_done");
      chk("t4_nA", nA, 64);
      chk("t4_nB", nB, 7);
      chk("t4_vcnt", vcnt, 256);
      chk("t4_dcnt", dcnt, 1);

      // iStart held through the run and the done edge
      @(negedge clk); #1;
      da = 8'd32; db = 8'd5; start = 1; clr();
      wait_done("t5_done1");
      chk("t5_vcnt1", vcnt, 256);
      chk("t5_dcnt1", dcnt, 1);
      chk("t5_nA1", nA, 32);
      chk("t5_nB1", nB, 5);
      chk("t5_gap", bus0.oValid, 0);
      chk("t5_cap", bus0.oBusy, 1);
      clr();
      start = 0;
      @(negedge clk); #1;
      chk("t5_resume", bus0.oValid, 1);
      wait_done("t5_done2");
      chk("t5_vcnt2", vcnt, 256);
      chk("t5_nA2", nA, 32);
      chk("t5_nB2", nB, 5);
      chk("t5_dcnt2", dcnt, 1);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ustream_gen2.md
Name: ustream_gen2

Overview:
- Dual-channel unary bitstream generator: the stage directly upstream of the scaled unary subtractor and adder in the scaler_SFFT datapath.
- Converts two unsigned binary operands into two unipolar bitstreams of exactly 2^BITWIDTH cycles.
- Each stream compares the operand against a deterministic low-discrepancy sequence, so the ones-count of each stream equals its operand exactly.
- Channel A uses the bit-reversed counter (van der Corput); channel B uses the plain counter (thermometer/ramp). This gives the two operands the low-correlation pairing the downstream subtractor expects.

Parameters:
- BITWIDTH, 8, operand width; stream length = 2^BITWIDTH cycles.
- INVB, 0, when 1 channel B output is inverted (~bit), for pre-inverted operand feeds.

Ports:
- iClk  input  1  clock, rising-edge.
- iRst  input  1  asynchronous, active-high reset.
- iStart  input  1  start request; sampled only in IDLE.
- iDataA  input  BITWIDTH  operand A, unsigned, value/2^BITWIDTH.
- iDataB  input  BITWIDTH  operand B, unsigned.
- oA  output  1  stream A bit.
- oB  output  1  stream B bit.
- oValid  output  1  oA/oB carry a stream bit this cycle.
- oBusy  output  1  high while in RUN.
- oDone  output  1  one-cycle pulse after the last stream bit.

Behaviour:
- Reset (async, iRst=1):
  - state=IDLE; cnt=0; dataA/dataB regs=0.
  - oA=0, oB=0, oValid=0, oBusy=0, oDone=0.
  - Applies immediately, including mid-stream; a partial stream is abandoned and not resumed.
- States: IDLE, RUN.
- IDLE:
  - oValid<=0; oA<=0; oB<=0.
  - On an edge with iStart=1: latch iDataA/iDataB, cnt<=0, state<=RUN, oBusy<=1.
- RUN, every edge:
  - oA<=(bitrev(cnt) < dataA).
  - oB<=(cnt < dataB) XOR INVB.
  - oValid<=1; cnt<=cnt+1 (BITWIDTH-bit, wraps).
  - iStart is ignored; operand inputs are ignored (operands are frozen at capture).
  - When cnt == 2^BITWIDTH-1: state<=IDLE, oBusy<=0. This edge still produces the final valid bit.
- Latency:
  - iStart sampled at edge k; first valid bit registered at edge k+1, so it is visible after edge k+1.
  - oValid is high for exactly 2^BITWIDTH consecutive cycles.
  - oDone<=1 at the first edge after the final bit (the same edge oValid falls); oDone<=0 otherwise.
- Back-to-back: iStart high on the IDLE edge that raises oDone is accepted. Result: oValid has a one-cycle gap, and oDone and the new capture coincide.
- Arithmetic: comparisons are unsigned BITWIDTH-bit.
  - Ones-count of A = dataA exactly; ones-count of B = dataB exactly (with INVB=0).
  - 1.0 is not representable; maximum is (2^BITWIDTH-1)/2^BITWIDTH.
- No X on outputs at any time after reset.

Decomposition:
- Shared package/header: state encoding (IDLE=1'b0, RUN=1'b1) and a bitrev function of width BITWIDTH. Guard the header with the include-guard style used across the datapath.
- One natural sub-module: ucmp_sng (comparator: sequence value vs operand -> bit). Instantiate it twice, once per channel.
- FSM, counter and handshake stay in the top module.

Test Plan:
- BITWIDTH=8, iDataA=128, iDataB=3, pulse iStart -> oValid high 256 cycles; A ones=128, alternating 1,0,1,0...; B=1,1,1 then 253 zeros; oDone pulses once, one cycle after the last valid bit.
- iDataA=0, iDataB=255 -> A all 0; B 255 ones then a final 0; ones-counts are 0 and 255.
- iDataA=255 -> A ones=255, with the only 0 at cnt=255 (the last bit); verify cnt wrap with no extra bit.
- Assert iRst at cycle 100 of a run, release, start with iDataA=64 -> all outputs 0 during reset; the new run gives exactly 64 ones and no residue from the aborted run.
- iStart held high during RUN and also on the done edge -> no restart mid-run; a second run starts with a one-cycle oValid gap and oDone coinciding with the capture.
- INVB=1, iDataA=192, iDataB=64, stream into the downstream scaled subtractor -> B ones=192; subtractor output ones-count = (192+192)/2 = 192 ±1.
